accel_job_scheduler: RTL

ACCEL_JOB_SCHEDULER -- requirements
Module: accel_job_scheduler

---
 rtl/accel_job_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/accel_job_scheduler.sv
// accel_job_scheduler: queues host-staged cipher DMA jobs and programs
// the accelerator register port one job at a time.
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   hs_write          host write strobe (single cycle)
//   hs_address        host byte address, word = [4:2]
//   hs_writedata      host write data
//   hs_readdata       host read data (combinational)
//   acc_write         accelerator register write strobe
//   acc_address       accelerator byte address
//   acc_writedata     accelerator write data
//   acc_irq           accelerator completion level
//   done_irq          one-cycle pulse per finished job
module accel_job_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hs_write,
  input  logic [4:0]  hs_address,
  input  logic [31:0] hs_writedata,
  output logic [31:0] hs_readdata,
  output logic        acc_write,
  output logic [4:0]  acc_address,
  output logic [31:0] acc_writedata,
  input  logic        acc_irq,
  output logic        done_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [2:0] {
    IDLE,
    PROG,
    START,
    WAIT_IRQ,
    CLEAR,
    DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   stg_q [7];
  logic [31:0]   mem_q [DEPTH][7];
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic [7:0]    done_cnt_q;
  logic          done_irq_q;

  logic [2:0]    word;
  logic          unused_addr_bits;
  logic          ctrl_wr;
  logic          push_req;
  logic          push;
  logic          clr;
  logic          pop;
  logic          full;
  logic          empty;

  assign word             = hs_address[4:2];
  assign unused_addr_bits = ^hs_address[1:0];
  assign ctrl_wr          = hs_write && (word == 3'd7);
  assign push_req         = ctrl_wr && hs_writedata[0];
  assign clr              = ctrl_wr && hs_writedata[1];
  assign full             = (count_q == FULL_CNT);
  assign empty            = (count_q == '0);
  assign push             = push_req && !full;
  assign done_irq         = done_irq_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = PROG;
          idx_d   = 3'd0;
        end
      end
      PROG: begin
        if (idx_q == 3'd6) begin
          state_d = START;
          idx_d   = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      START:    state_d = WAIT_IRQ;
      WAIT_IRQ: if (acc_irq) state_d = CLEAR;
      CLEAR:    state_d = DRAIN;
      DRAIN: begin
        // Head stays queued (and counted) until the
        // accelerator has fully released its irq.
        if (!acc_irq) begin
          state_d = IDLE;
          pop     = 1'b1;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      done_cnt_q <= 8'd0;
      done_irq_q <= 1'b0;
      for (int i = 0; i < 7; i++) stg_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      done_irq_q <= pop;
      if (hs_write && word != 3'd7) stg_q[word] <= hs_writedata;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (pop) done_cnt_q <= done_cnt_q + 8'd1;
      if (push_req && full) ovf_q <= 1'b1;
      // Clear is applied after the push/pop effects so it wins.
      if (clr) begin
        ovf_q      <= 1'b0;
        done_cnt_q <= 8'd0;
      end
    end
  end

  // Job payload storage needs no reset; occupancy is tracked above.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 7; i++) mem_q[tail_q][i] <= stg_q[i];
    end
  end

  always_comb begin
    acc_write     = 1'b0;
    acc_address   = 5'd0;
    acc_writedata = 32'd0;
    unique case (state_q)
      PROG: begin
        acc_write     = 1'b1;
        acc_address   = {idx_q, 2'b00};
        acc_writedata = mem_q[head_q][idx_q];
      end
      START: begin
        acc_write     = 1'b1;
        acc_address   = 5'h1C;
        acc_writedata = 32'd1;
      end
      CLEAR: begin
        acc_write     = 1'b1;
        acc_address   = 5'h1C;
        acc_writedata = 32'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    hs_readdata = '0;
    if (word == 3'd7) begin
      hs_readdata = {8'd0, done_cnt_q, 8'd0, 4'(count_q),
                     ovf_q, full, empty, state_q != IDLE};
    end else begin
      hs_readdata = stg_q[word];
    end
  end

endmodule
